// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the fifo library (synchronous and asynchronous
// FIFOs).
//   clog2       : constant-foldable ceiling log2, used to size counters
//   fifo_err_e  : common encoding of the FIFO error flags
// ---------------------------------------------------------------------------
package fifo_pkg;

    // Ceiling log2 usable in parameter/localparam expressions. clog2(1) = 0,
    // clog2(2) = 1, clog2(5) = 3. Kept here so every FIFO sizes its counters
    // the same way.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Error flag encoding shared by the synchronous and asynchronous FIFOs,
    // so status registers built on top of either look identical.
    typedef enum logic [1:0] {
        FIFO_ERR_NONE = 2'b00,
        FIFO_ERR_OVF  = 2'b01,
        FIFO_ERR_UDF  = 2'b10
    } fifo_err_e;

endpackage

// File: rtl/simple_dpram_sclk.sv
// ---------------------------------------------------------------------------
// simple_dpram_sclk
// Single-clock simple dual-port RAM with a registered read port. The read
// register only loads when i_re is high, so it holds its last value
// otherwise. The array has no reset.
//   i_clk    : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_re     : read enable (loads the output register)
//   i_raddr  : read address
//   o_rdata  : registered read data
// Parameters: ADDR_WIDTH, DATA_WIDTH, ENABLE_BYPASS (forward write data when
// a read and write hit the same address in the same cycle).
// ---------------------------------------------------------------------------
module simple_dpram_sclk #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter bit ENABLE_BYPASS = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage array write port. Deliberately unreset so it maps onto block
    // or distributed RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port. With bypass enabled a same-address write wins
    // over the stale array contents; without it, the caller guarantees the
    // two addresses never collide while both enables are high.
    generate
        if (ENABLE_BYPASS) begin : g_bypass
            always_ff @(posedge i_clk) begin
                if (i_re) begin
                    if (i_we && (i_waddr == i_raddr)) begin
                        r_rdata <= i_wdata;
                    end else begin
                        r_rdata <= r_mem[i_raddr];
                    end
                end
            end
        end else begin : g_noBypass
            always_ff @(posedge i_clk) begin
                if (i_re) begin
                    r_rdata <= r_mem[i_raddr];
                end
            end
        end
    endgenerate

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO controller. The RAM's registered
// read port doubles as the head slot, so capacity is 2^ADDR_WIDTH + 1 words.
//   i_clk    : clock, all state on rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_flush  : synchronous clear of all occupancy (beats push/pop)
//   i_push   : write request
//   i_din    : write data
//   i_pop    : consume head word (only meaningful while o_valid)
//   o_dout   : head word, undefined while o_valid is low
//   o_valid  : head word present
//   o_full   : a push this cycle will be dropped
//   o_afull  : o_count >= AFULL_LEVEL
//   o_count  : words held (RAM plus head)
//   o_ovf    : one-cycle pulse, a push was dropped
//   o_udf    : one-cycle pulse, pop while empty
// ---------------------------------------------------------------------------
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_valid,
    output logic                  o_full,
    output logic                  o_afull,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_ovf,
    output logic                  o_udf
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int CNT_WIDTH = clog2(DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_DEPTH = CNT_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [CNT_WIDTH-1:0]  r_ramCnt;
    logic                  r_valid;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_full;
    logic                  w_we;
    logic                  w_re;
    logic [CNT_WIDTH-1:0]  w_count;

    // Full looks only at registered RAM occupancy, so a pop in the same
    // cycle never frees room for a push. That keeps the write and read
    // addresses apart whenever both fire, so the RAM needs no bypass.
    assign w_full = (r_ramCnt == CNT_DEPTH);

    // A RAM read refills the head slot whenever it is empty or being
    // consumed this cycle; flush suppresses both RAM ports.
    assign w_we = i_push && !w_full && !i_flush;
    assign w_re = (r_ramCnt != '0) && (!r_valid || i_pop) && !i_flush;

    assign w_count = r_ramCnt + {{(CNT_WIDTH-1){1'b0}}, r_valid};

    // Pointer, occupancy and pulse-flag state. Flush returns everything to
    // the empty state without raising error pulses; otherwise the RAM
    // occupancy tracks writes minus reads and the head-valid bit is set by a
    // refill and cleared by a pop that has nothing behind it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_ramCnt <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (i_flush) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_ramCnt <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_we) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_re) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_we && !w_re) begin
                r_ramCnt <= r_ramCnt + CNT_ONE;
            end else if (!w_we && w_re) begin
                r_ramCnt <= r_ramCnt - CNT_ONE;
            end
            if (w_re) begin
                r_valid <= 1'b1;
            end else if (i_pop) begin
                r_valid <= 1'b0;
            end
            r_ovf <= i_push && w_full;
            r_udf <= i_pop && !r_valid;
        end
    end

    // Storage. The read register of this RAM is the visible head word.
    simple_dpram_sclk #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .ENABLE_BYPASS (1'b0)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (i_din),
        .i_re    (w_re),
        .i_raddr (r_rptr),
        .o_rdata (o_dout)
    );

    assign o_valid = r_valid;
    assign o_full  = w_full;
    assign o_count = w_count;
    assign o_afull = (32'(w_count) >= AFULL_LEVEL);
    assign o_ovf   = r_ovf;
    assign o_udf   = r_udf;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_fwft
// Directed and randomized stimulus for sync_fifo_fwft (ADDR_WIDTH=2, five
// words of capacity) against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_sync_fifo_fwft;

    localparam int ADDR_WIDTH = 2;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int AFULL_LVL  = DEPTH - 2;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic                  push;
    logic [DATA_WIDTH-1:0] din;
    logic                  pop;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;
    logic                  full;
    logic                  afull;
    logic [ADDR_WIDTH:0]   count;
    logic                  ovf;
    logic                  udf;

    int errors = 0;
    int checks = 0;

    // Reference model: every word held, oldest first, plus whether the
    // oldest word is already visible at the output.
    logic [DATA_WIDTH-1:0] modelQ[$];
    bit                    modelShown;
    bit                    expOvf;
    bit                    expUdf;

    sync_fifo_fwft #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .AFULL_LEVEL (AFULL_LVL)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_push  (push),
        .i_din   (din),
        .i_pop   (pop),
        .o_dout  (dout),
        .o_valid (valid),
        .o_full  (full),
        .o_afull (afull),
        .o_count (count),
        .o_ovf   (ovf),
        .o_udf   (udf)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counted, and reported on mismatch.
    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare every DUT output with what the model predicts right now.
    task automatic checkOutput(input string tag);
        int held;
        held = modelQ.size();
        checkValue({tag, ".valid"}, 32'(valid), 32'(modelShown));
        checkValue({tag, ".count"}, 32'(count), held);
        checkValue({tag, ".full"}, 32'(full), 32'((held - int'(modelShown)) == DEPTH));
        checkValue({tag, ".afull"}, 32'(afull), 32'(held >= AFULL_LVL));
        checkValue({tag, ".ovf"}, 32'(ovf), 32'(expOvf));
        checkValue({tag, ".udf"}, 32'(udf), 32'(expUdf));
        if (modelShown) begin
            checkValue({tag, ".dout"}, 32'(dout), 32'(modelQ[0]));
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, advance the model
    // by the same cycle and compare. Words not yet visible sit behind the
    // head; the head is refilled whenever it is empty or being consumed.
    task automatic applyStimulus(input bit doPush, input logic [DATA_WIDTH-1:0] data,
                                 input bit doPop, input bit doFlush, input string tag);
        int  waiting;
        bit  accept;
        bit  refill;
        waiting = modelQ.size() - int'(modelShown);
        accept  = doPush && (waiting < DEPTH) && !doFlush;
        refill  = (waiting > 0) && (!modelShown || doPop) && !doFlush;
        push  = doPush;
        din   = data;
        pop   = doPop;
        flush = doFlush;
        @(posedge clk);
        #1;
        if (doFlush) begin
            modelQ.delete();
            modelShown = 1'b0;
            expOvf     = 1'b0;
            expUdf     = 1'b0;
        end else begin
            expOvf = doPush && (waiting == DEPTH);
            expUdf = doPop && !modelShown;
            if (doPop && modelShown) begin
                void'(modelQ.pop_front());
            end
            if (accept) begin
                modelQ.push_back(data);
            end
            if (refill) begin
                modelShown = 1'b1;
            end else if (doPop) begin
                modelShown = 1'b0;
            end
        end
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        checkOutput(tag);
    endtask

    // Asynchronous reset in the middle of a cycle: outputs must clear
    // without waiting for an edge.
    task automatic applyReset(input string tag);
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        modelQ.delete();
        modelShown = 1'b0;
        expOvf     = 1'b0;
        expUdf     = 1'b0;
        checkOutput(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, ".idle"});
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        push       = 1'b0;
        din        = '0;
        pop        = 1'b0;
        modelShown = 1'b0;
        expOvf     = 1'b0;
        expUdf     = 1'b0;

        // Reset held, then released and idled.
        #3;
        checkOutput("rst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 8'h00, 0, 0, "idle0");
        applyStimulus(0, 8'h00, 0, 0, "idle1");
        checkValue("idle.count", 32'(count), 0);

        // Single word fall-through takes two edges.
        applyStimulus(1, 8'hA1, 0, 0, "ft.push");
        checkValue("ft.notyet", 32'(valid), 0);
        applyStimulus(0, 8'h00, 0, 0, "ft.wait");
        checkValue("ft.valid", 32'(valid), 1);
        checkValue("ft.dout", 32'(dout), 32'hA1);
        applyStimulus(0, 8'h00, 1, 0, "ft.pop");
        checkValue("ft.empty", 32'(valid), 0);
        checkValue("ft.count", 32'(count), 0);

        // Fill to capacity, overflow once, drain in order.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, 8'(i), 0, 0, "fill");
        end
        checkValue("fill.full", 32'(full), 1);
        checkValue("fill.count", 32'(count), 5);
        applyStimulus(1, 8'h66, 0, 0, "fill.ovf");
        checkValue("ovf.pulse", 32'(ovf), 1);
        checkValue("ovf.count", 32'(count), 5);
        for (int i = 1; i <= 5; i++) begin
            checkValue("drain.dout", 32'(dout), i);
            applyStimulus(0, 8'h00, 1, 0, "drain");
        end
        checkValue("drain.valid", 32'(valid), 0);

        // Half full, then sustained push+pop wraps the pointers.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'(8'h10 + i), 0, 0, "half");
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 8'(8'h20 + i), 1, 0, "stream");
            checkValue("stream.count", 32'(count), 3);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 8'h00, 1, 0, "stream.drain");
        end

        // Full with push and pop together: push dropped, pop honoured.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 8'(8'h40 + i), 0, 0, "refill");
        end
        applyStimulus(1, 8'h99, 1, 0, "fullpp");
        checkValue("fullpp.ovf", 32'(ovf), 1);
        checkValue("fullpp.count", 32'(count), 4);
        checkValue("fullpp.dout", 32'(dout), 32'h41);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 8'h00, 1, 0, "fullpp.drain");
        end

        // Underflow pulse, then flush beating a push.
        applyStimulus(0, 8'h00, 1, 0, "udf");
        checkValue("udf.pulse", 32'(udf), 1);
        applyStimulus(0, 8'h00, 0, 0, "udf.clear");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'(8'h50 + i), 0, 0, "preflush");
        end
        applyStimulus(1, 8'h77, 0, 1, "flush");
        checkValue("flush.count", 32'(count), 0);
        checkValue("flush.ovf", 32'(ovf), 0);
        applyStimulus(1, 8'h5A, 0, 0, "postflush.push");
        applyStimulus(0, 8'h00, 0, 0, "postflush.wait");
        checkValue("postflush.dout", 32'(dout), 32'h5A);
        applyStimulus(0, 8'h00, 1, 0, "postflush.pop");

        // Reset while traffic is in flight.
        applyStimulus(1, 8'h31, 0, 0, "pre.rst0");
        applyStimulus(1, 8'h32, 1, 0, "pre.rst1");
        applyStimulus(1, 8'h33, 0, 0, "pre.rst2");
        applyReset("midrst");

        // Randomized traffic with occasional flush and one reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                applyReset("rand.rst");
            end
            applyStimulus($urandom_range(0, 99) < 60,
                          8'($urandom),
                          $urandom_range(0, 99) < 55,
                          $urandom_range(0, 63) == 0,
                          "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
